// File: rtl/video_pattern_gen.sv
// Raster timing generator with built-in test patterns, one pixel per clock.
// Outputs are registered one cycle after the counter state that produces them.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | counters held at 0, syncs inactive, no video, busy low
// S_RUN   | counters free-run, frames repeat while en is high
// S_DRAIN | en dropped: finish the current frame, then go idle
//           (en seen again returns straight to S_RUN)
module video_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int ADDR_W   = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   hs,
  output logic                   vs,
  output logic                   de,
  output logic [15:0]            x,
  output logic [15:0]            y,
  output logic [ADDR_W-1:0]      address,
  output logic                   frame_start,
  output logic                   line_start,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic [15:0]            frame_cnt,
  output logic                   busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [HW-1:0]          h_q, h_d;
  logic [VW-1:0]          v_q, v_d;
  logic [BW-1:0]          bar_px_q, bar_px_d;
  logic [2:0]             bar_idx_q, bar_idx_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [1:0]             mode_q, mode_d;
  logic [3*COLOR_W-1:0]   solid_q, solid_d;

  logic                   hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [15:0]            x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]      address_q, address_d;
  logic                   frame_start_q, frame_start_d, line_start_q, line_start_d;
  logic [COLOR_W-1:0]     red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   busy_q, busy_d;

  logic active, frame_wrap, frame_origin, de_now;

  assign active       = (state_q != S_IDLE);
  assign frame_wrap   = active && (h_q == H_LAST) && (v_q == V_LAST);
  assign frame_origin = (h_q == '0) && (v_q == '0);
  assign de_now       = active && (h_q < H_ACT) && (v_q < V_ACT);

  // Run/drain/idle sequencing; a drain always ends on a frame wrap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en) state_d = S_RUN;
      S_RUN:   if (!en) state_d = S_DRAIN;
      S_DRAIN: begin
        if (en)              state_d = S_RUN;
        else if (frame_wrap) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Raster counters, bar sub-counter, incremental address and frame-aligned pattern latch.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!active) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end else begin
      h_d = h_q + HW'(1);
    end

    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (h_d == '0) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (bar_px_q == BAR_LAST) begin
      bar_px_d  = '0;
      bar_idx_d = bar_idx_q + 3'd1;
    end else begin
      bar_px_d  = bar_px_q + BW'(1);
    end

    addr_d = addr_q;
    if ((h_d == '0) && (v_d == '0)) addr_d = '0;
    else if (de_now)                addr_d = addr_q + ADDR_W'(1);

    // The latched value is also what the origin pixel itself uses.
    mode_d  = frame_origin ? mode      : mode_q;
    solid_d = frame_origin ? solid_rgb : solid_q;
  end

  // Output values for the current counter state.
  always_comb begin
    hs_d          = (active && (h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? HS_POL : ~HS_POL;
    vs_d          = (active && (v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? VS_POL : ~VS_POL;
    de_d          = de_now;
    x_d           = de_now ? 16'(h_q) : 16'd0;
    y_d           = de_now ? 16'(v_q) : 16'd0;
    address_d     = de_now ? addr_q : '0;
    frame_start_d = de_now && frame_origin;
    line_start_d  = de_now && (h_q == '0);
    frame_cnt_d   = frame_wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;
    busy_d        = active;

    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (de_now) begin
      case (mode_d)
        2'd0: {red_d, green_d, blue_d} = solid_d;
        2'd1: begin
          red_d   = {COLOR_W{~bar_idx_q[1]}};
          green_d = {COLOR_W{~bar_idx_q[2]}};
          blue_d  = {COLOR_W{~bar_idx_q[0]}};
        end
        2'd2: begin
          red_d   = x_d[COLOR_W-1:0];
          green_d = x_d[COLOR_W-1:0];
          blue_d  = x_d[COLOR_W-1:0];
        end
        default: begin
          red_d   = {COLOR_W{x_d[4] ^ y_d[4]}};
          green_d = {COLOR_W{x_d[4] ^ y_d[4]}};
          blue_d  = {COLOR_W{x_d[4] ^ y_d[4]}};
        end
      endcase
    end
  end

  // Control state and raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      h_q       <= '0;
      v_q       <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      addr_q    <= '0;
      mode_q    <= '0;
      solid_q   <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      solid_q   <= solid_d;
    end
  end

  // Output registers, all aligned to the same counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      address_q     <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      frame_cnt_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      address_q     <= address_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      frame_cnt_q   <= frame_cnt_d;
      busy_q        <= busy_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign address     = address_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a reduced raster (64x40 active, 80x47 total).
module tb_video_pattern_gen;

  localparam int HA = 64, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA = 40, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;
  localparam int AW = 12;
  localparam bit HSP = 1'b1;
  localparam bit VSP = 1'b0;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic clk, rst, en;
  logic [1:0] mode;
  logic [23:0] solid_rgb;
  logic hs, vs, de, frame_start, line_start, busy;
  logic [15:0] x, y, frame_cnt;
  logic [AW-1:0] address;
  logic [7:0] red, green, blue;

  int tests = 0;
  int fails = 0;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .COLOR_W(8), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .hs(hs), .vs(vs), .de(de), .x(x), .y(y), .address(address),
    .frame_start(frame_start), .line_start(line_start),
    .red(red), .green(green), .blue(blue), .frame_cnt(frame_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mst_t;
  mst_t        m_st = M_IDLE;
  int          m_pos = 0;
  int          m_fcnt = 0;
  int          m_mode = 0;
  logic [23:0] m_solid = '0;
  logic        m_valid = 1'b0;
  int          mh, mv;
  logic        m_act, m_wrap;

  logic        e_hs, e_vs, e_de, e_fs, e_ls, e_busy;
  int          e_x, e_y, e_addr, e_fcnt;
  logic [23:0] e_rgb;

  function automatic logic [23:0] pixel(input int md, input logic [23:0] sc, input int px, input int py);
    case (md)
      0: return sc;
      1: return BARS[px / (HA / 8)];
      2: return {3{8'(px % 256)}};
      default: return (((px / 16) + (py / 16)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_st = M_IDLE; m_pos = 0; m_fcnt = 0; m_mode = 0; m_solid = '0;
      e_hs = !HSP; e_vs = !VSP; e_de = 0; e_fs = 0; e_ls = 0; e_busy = 0;
      e_x = 0; e_y = 0; e_addr = 0; e_fcnt = 0; e_rgb = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_act = (m_st != M_IDLE);
      mh = m_pos % HT;
      mv = m_pos / HT;
      if (m_pos == 0) begin
        m_mode = int'(mode);
        m_solid = solid_rgb;
      end
      e_de   = m_act && mh < HA && mv < VA;
      e_hs   = (m_act && mh >= HA + HFP && mh < HA + HFP + HSY) ? HSP : !HSP;
      e_vs   = (m_act && mv >= VA + VFP && mv < VA + VFP + VSY) ? VSP : !VSP;
      e_x    = e_de ? mh : 0;
      e_y    = e_de ? mv : 0;
      e_addr = e_de ? mv * HA + mh : 0;
      e_fs   = e_de && m_pos == 0;
      e_ls   = e_de && mh == 0;
      e_rgb  = e_de ? pixel(m_mode, m_solid, mh, mv) : 24'h0;
      e_busy = m_act;
      m_wrap = m_act && m_pos == FT - 1;
      if (m_act) m_pos = m_wrap ? 0 : m_pos + 1;
      if (m_wrap) m_fcnt = (m_fcnt + 1) % 65536;
      e_fcnt = m_fcnt;
      case (m_st)
        M_IDLE:  if (en) m_st = M_RUN;
        M_RUN:   if (!en) m_st = M_DRAIN;
        default: if (en) m_st = M_RUN; else if (m_wrap) m_st = M_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if (hs !== e_hs || vs !== e_vs || de !== e_de || x !== 16'(e_x) || y !== 16'(e_y) ||
          address !== AW'(e_addr) || frame_start !== e_fs || line_start !== e_ls ||
          {red, green, blue} !== e_rgb || frame_cnt !== 16'(e_fcnt) || busy !== e_busy) begin
        fails++;
        $display("FAIL model_cmp t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d a=%0d fs=%b ls=%b rgb=%h fc=%0d busy=%b want hs=%b vs=%b de=%b x=%0d y=%0d a=%0d fs=%b ls=%b rgb=%h fc=%0d busy=%b",
                 $time, hs, vs, de, x, y, address, frame_start, line_start, {red, green, blue}, frame_cnt, busy,
                 e_hs, e_vs, e_de, e_x, e_y, e_addr, e_fs, e_ls, e_rgb, e_fcnt, e_busy);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_pix(input int px, input int py, input string name);
    int n = 0;
    while (!(de === 1'b1 && int'(x) == px && int'(y) == py) && n < 2 * FT) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n < 2 * FT), 64'd1);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 2 * FT);
  endtask

  int n, n_de, n_ls, n_fs, n_hs, n_vs, max_addr, bad_rgb, first_hs, first_vs, chg, misplaced, fc0, min_busy;
  logic [23:0] line0 [HA];

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; solid_rgb = 24'h123456;
    repeat (3) @(negedge clk);
    check("rst_hs", 64'(hs), 64'(!HSP));
    check("rst_vs", 64'(vs), 64'(!VSP));
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    en = 1'b1;
    wait_fs(n);
    check("start_latency", 64'(n), 64'd2);

    // one full frame of solid colour
    n_de = 0; n_ls = 0; n_fs = 0; n_hs = 0; n_vs = 0; max_addr = 0; bad_rgb = 0;
    first_hs = -1; first_vs = -1;
    for (int i = 0; i < FT; i++) begin
      if (i > 0) @(negedge clk);
      n_de += int'(de); n_ls += int'(line_start); n_fs += int'(frame_start);
      if (hs == HSP) begin n_hs++; if (first_hs < 0) first_hs = i; end
      if (vs == VSP) begin n_vs++; if (first_vs < 0) first_vs = i; end
      if (de && int'(address) > max_addr) max_addr = int'(address);
      if (de && {red, green, blue} != 24'h123456) bad_rgb++;
    end
    check("de_per_frame", 64'(n_de), 64'd2560);
    check("line_starts", 64'(n_ls), 64'd40);
    check("frame_starts", 64'(n_fs), 64'd1);
    check("hs_cycles", 64'(n_hs), 64'(6 * 47));
    check("hs_first", 64'(first_hs), 64'd68);
    check("vs_cycles", 64'(n_vs), 64'd160);
    check("vs_first", 64'(first_vs), 64'd3360);
    check("max_address", 64'(max_addr), 64'd2559);
    check("solid_rgb_bad", 64'(bad_rgb), 64'd0);
    @(negedge clk);
    check("frame_period", 64'(frame_start), 64'd1);
    check("addr_restart", 64'(address), 64'd0);
    check("frame_cnt_1", 64'(frame_cnt), 64'd1);

    // colour bars take effect on the next frame
    mode = 2'd1;
    wait_fs(n);
    for (int i = 0; i < HA; i++) begin
      if (i > 0) @(negedge clk);
      line0[i] = {red, green, blue};
    end
    check("bar_x0", 64'(line0[0]), 64'hFFFFFF);
    check("bar_x8", 64'(line0[8]), 64'hFFFF00);
    check("bar_x63", 64'(line0[63]), 64'h000000);
    chg = 0; misplaced = 0;
    for (int i = 1; i < HA; i++) begin
      if (line0[i] != line0[i-1]) begin
        chg++;
        if (i % 8 != 0) misplaced++;
      end
    end
    check("bar_changes", 64'(chg), 64'd7);
    check("bar_misplaced", 64'(misplaced), 64'd0);

    // switch to checkerboard mid-frame
    wait_pix(0, 10, "wait_y10");
    mode = 2'd3;
    wait_pix(12, 20, "wait_x12y20");
    check("still_bars", 64'({red, green, blue}), 64'hFFFF00);
    wait_fs(n);
    wait_pix(16, 0, "wait_x16y0");
    check("chk_16_0", 64'({red, green, blue}), 64'hFFFFFF);
    wait_pix(16, 16, "wait_x16y16");
    check("chk_16_16", 64'({red, green, blue}), 64'h000000);

    // drop en mid-frame: frame drains then idles
    wait_pix(0, 20, "wait_y20");
    fc0 = int'(frame_cnt);
    en = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 2 * FT) begin @(negedge clk); n++; end
    check("drain_done", 64'(busy), 64'd0);
    check("drain_fcnt", 64'(frame_cnt), 64'(fc0 + 1));
    check("idle_hs", 64'(hs), 64'(!HSP));
    check("idle_vs", 64'(vs), 64'(!VSP));
    check("idle_de", 64'(de), 64'd0);

    // re-raising en during drain keeps the frame contiguous
    mode = 2'd2;
    en = 1'b1;
    wait_fs(n);
    n = 0; min_busy = 1;
    do begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1) min_busy = 0;
      if (n == 5 * HT) en = 1'b0;
      if (n == 5 * HT + 100) en = 1'b1;
    end while (frame_start !== 1'b1 && n < 2 * FT);
    check("contig_period", 64'(n), 64'(FT));
    check("contig_busy", 64'(min_busy), 64'd1);

    // randomized run checked by the model
    for (int i = 0; i < 4 * FT; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) en = !en;
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) solid_rgb = 24'($urandom);
    end

    // single-cycle reset mid-frame
    en = 1'b1;
    wait_pix(30, 30, "wait_x30y30");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_hs", 64'(hs), 64'(!HSP));
    check("mrst_vs", 64'(vs), 64'(!VSP));
    check("mrst_de", 64'(de), 64'd0);
    check("mrst_xy", 64'({x, y}), 64'd0);
    check("mrst_addr", 64'(address), 64'd0);
    check("mrst_pulses", 64'({frame_start, line_start}), 64'd0);
    check("mrst_rgb", 64'({red, green, blue}), 64'd0);
    check("mrst_fcnt", 64'(frame_cnt), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    wait_fs(n);
    check("restart_latency", 64'(n), 64'd2);
    wait_fs(n);
    check("restart_period", 64'(n), 64'(FT));
    check("restart_fcnt", 64'(frame_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Parametrised raster timing generator with a built-in test-pattern source, one pixel per clock.
- Drives the VGA-input capture path in simulation and on hardware: HSYNC/VSYNC of selectable polarity, data enable, pixel coordinates, linear frame-buffer address and 3-channel colour.
- Adds over the fixed-mode timing generator: programmable porches and polarity, start/stop with a clean frame drain, frame-aligned pattern switching, and frame counting.

Parameters:
- H_ACTIVE, 640, active pixels per line; must be a multiple of 8.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, active lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- HS_POL, 0, HSYNC active level (0 = active-low).
- VS_POL, 0, VSYNC active level (0 = active-low).
- COLOR_W, 8, bits per colour channel.
- ADDR_W, 19, address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  run request.
- mode  in  2  pattern select: 0 solid, 1 colour bars, 2 horizontal gradient, 3 checkerboard.
- solid_rgb  in  3*COLOR_W  {R,G,B} colour used in mode 0.
- hs  out  1  horizontal sync, at HS_POL level while asserted.
- vs  out  1  vertical sync, at VS_POL level while asserted.
- de  out  1  active-video enable.
- x  out  16  active pixel column; 0 when de=0.
- y  out  16  active line; 0 when de=0.
- address  out  ADDR_W  linear pixel index y*H_ACTIVE+x; valid when de=1.
- frame_start  out  1  one-cycle pulse on the first active pixel of each frame.
- line_start  out  1  one-cycle pulse on the first active pixel of each line.
- red, green, blue  out  COLOR_W each  pattern pixel; 0 when de=0.
- frame_cnt  out  16  completed-frame counter.
- busy  out  1  high while in RUN or DRAIN.

Behaviour:
- Synchronous active-high reset, single clock domain, everything in the clk domain.
- Line order: active, front porch, sync, back porch. H_TOTAL is the sum of the four H values (800 by default).
- Frame order follows the same pattern vertically. V_TOTAL is the sum of the four V values (525 by default).
- Counters h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1.
  - h_cnt wraps to 0 and increments v_cnt.
  - v_cnt wraps to 0 at V_TOTAL-1 with h_cnt=H_TOTAL-1.
- All outputs are registered and mutually aligned, one cycle after the counter state that produces them.
- HSYNC asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- VSYNC asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for whole lines aligned to h_cnt=0.
- de = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
- address is computed incrementally, with no multiplier:
  - cleared at frame start;
  - +1 per de pixel;
  - ends each frame at H_ACTIVE*V_ACTIVE-1.
- State machine:
  - IDLE: counters held at 0; hs/vs at inactive level; de=0; busy=0. Moves to RUN when en=1, and the first counted cycle is h=0, v=0.
  - RUN: counters free-run. en=0 moves to DRAIN.
  - DRAIN: the current frame completes. At the final counter wrap, frame_cnt increments and the block goes to IDLE. If en=1 is seen in DRAIN it returns to RUN without a gap.
- mode and solid_rgb are latched only when h_cnt=0 and v_cnt=0 (the frame boundary). A mid-frame change takes effect on the next frame.
- Patterns:
  - Mode 1 (colour bars): 8 equal bars of H_ACTIVE/8 pixels, in the order white, yellow, cyan, green, magenta, red, blue, black. Full scale is all-ones, zero is 0. The bar index comes from a sub-counter, not a divider.
  - Mode 2 (horizontal gradient): R=G=B=x[COLOR_W-1:0], wrapping.
  - Mode 3 (checkerboard): white if x[4]^y[4], else black.
- frame_cnt increments on every v/h wrap in RUN or DRAIN and wraps from 0xFFFF to 0.
- Reset values:
  - hs = ~HS_POL and vs = ~VS_POL.
  - de, x, y, address, frame_start, line_start, colour, frame_cnt and busy are all 0.
  - State is IDLE and the latched mode is 0.
- Reset mid-frame: every output reaches its reset value on the cycle after rst is sampled high. There is no partial-frame completion.

Test Plan:
- Reset, then en=1, defaults:
  - hs low for exactly 96 cycles, starting 656 cycles after the de rise, period 800;
  - vs low for 2 full lines (1600 cycles) starting at line 490;
  - frame period 420000 cycles.
- One frame in mode 0 with solid_rgb=0x123456:
  - exactly 307200 de cycles, each with R/G/B = 0x12/0x34/0x56;
  - address runs 0 to 307199, then 0 on the next frame_start;
  - line_start fires 480 times;
  - frame_start fires once;
  - frame_cnt is 1 after the wrap.
- Mode 1: on line 0, colour changes exactly at x=80, 160, …, 560; x=0 is FF/FF/FF, x=80 is FF/FF/00, x=639 is 00/00/00.
- Switch mode 1→3 at line 100: the current frame stays bars to line 479; the next frame has x=16,y=0 white and x=16,y=16 black.
- Drop en at line 200: the frame completes, then IDLE with busy=0, hs/vs inactive, frame_cnt +1. Re-raising en during DRAIN gives a contiguous next frame.
- rst for 1 cycle at x=300,y=300: next cycle has all outputs at reset values. With HS_POL=1, VS_POL=1 and a 32x8 raster (H 32/2/4/2, V 8/1/1/1), hs is high for 4 cycles and de=256 per frame.
